// File: rtl/udp_snapshot_ctrl_if.sv
// Bus bundle for udp_snapshot_ctrl: an Avalon-MM register port plus the UDP payload stream.
// The master side drives requests and stream words; the slave side is the snapshot controller.
interface udp_snapshot_ctrl_if;
  logic [3:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        av_irq;
  logic [31:0] udp_data;
  logic        udp_data_valid;
  logic        udp_sop;
  logic        udp_eop;

  modport master (
    output address, write, read, writedata, udp_data, udp_data_valid, udp_sop, udp_eop,
    input  readdata, av_irq
  );

  modport slave (
    input  address, write, read, writedata, udp_data, udp_data_valid, udp_sop, udp_eop,
    output readdata, av_irq
  );
endinterface

// File: rtl/udp_snapshot_ctrl.sv
// Captures the first NUM_WORDS payload words of one UDP frame for readback over Avalon-MM.
// Define UDP_SNAP_TIMEOUT_EN to build the in-frame idle-gap timeout (TIMEOUT_CYCLES).
//
// state   | meaning
// IDLE    | not armed, stream ignored
// ARMED   | waiting for a start-of-frame word
// CAPTURE | storing frame words until eop
// READY   | snapshot frozen, waiting for ACK
module udp_snapshot_ctrl #(
  parameter int NUM_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  udp_snapshot_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_READY   = 2'd3;
  localparam logic [3:0] NW        = 4'(NUM_WORDS);

  logic [1:0]  state;
  logic        arm, cont, irq_en;
  logic [3:0]  count, length;
  logic        truncated, timeout;
  logic [15:0] drops;
  logic [31:0] words [0:7];
  logic [31:0] rdata, rd_mux;

  logic ctrl_wr, ack, drop_clr, abort, word_hit, sop_hit, eop_hit, room, drop_evt, timeout_hit;

  assign ctrl_wr  = bus.write && (bus.address == 4'd0);
  assign ack      = ctrl_wr && bus.writedata[1];
  assign drop_clr = ctrl_wr && bus.writedata[4];
  assign abort    = ctrl_wr && !bus.writedata[0] && (state == S_ARMED || state == S_CAPTURE);
  assign word_hit = bus.udp_data_valid;
  assign sop_hit  = word_hit && bus.udp_sop;
  assign eop_hit  = word_hit && bus.udp_eop;
  assign room     = count < NW;
  // A sop abandons a partial capture or arrives while the snapshot is held.
  assign drop_evt = sop_hit && (state == S_READY || (state == S_CAPTURE && !abort));

`ifdef UDP_SNAP_TIMEOUT_EN
  logic [15:0] gap;
  assign timeout_hit = (state == S_CAPTURE) && !word_hit && (gap == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               gap <= '0;
    else if (state != S_CAPTURE || word_hit)    gap <= '0;
    else                                        gap <= gap + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      arm       <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      count     <= '0;
      length    <= '0;
      truncated <= 1'b0;
      timeout   <= 1'b0;
      drops     <= '0;
      for (int i = 0; i < 8; i++) words[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        arm    <= bus.writedata[0];
        cont   <= bus.writedata[2];
        irq_en <= bus.writedata[3];
      end
      if (drop_clr)                          drops <= '0;
      else if (drop_evt && drops != 16'hFFFF) drops <= drops + 16'd1;

      case (state)
        S_IDLE: if (ctrl_wr && bus.writedata[0]) state <= S_ARMED;
        S_ARMED, S_CAPTURE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            length  <= count;
            state   <= S_READY;
          end else if (sop_hit) begin
            words[0]  <= bus.udp_data;
            count     <= 4'd1;
            truncated <= 1'b0;
            timeout   <= 1'b0;
            if (bus.udp_eop) begin
              length <= 4'd1;
              state  <= S_READY;
            end else begin
              state  <= S_CAPTURE;
            end
          end else if (word_hit && state == S_CAPTURE) begin
            if (room) begin
              words[count[2:0]] <= bus.udp_data;
              count             <= count + 4'd1;
            end else begin
              truncated <= 1'b1;
            end
            if (eop_hit) begin
              length <= room ? count + 4'd1 : NW;
              state  <= S_READY;
            end
          end
        end
        // ARM and CONT as written with the ACK decide where the next frame goes.
        S_READY: if (ack) state <= (bus.writedata[0] && bus.writedata[2]) ? S_ARMED : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      4'd0: rd_mux = {28'd0, irq_en, cont, 1'b0, arm};
      4'd1: rd_mux = {22'd0, timeout, truncated, length, 2'b00, state};
      4'd2: rd_mux = {16'd0, drops};
      default:
        if (bus.address >= 4'd3 && bus.address < 4'(3 + NUM_WORDS))
          rd_mux = words[3'(bus.address - 4'd3)];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      rdata <= '0;
    else if (bus.read) rdata <= rd_mux;
  end

  assign bus.readdata = rdata;
  assign bus.av_irq   = irq_en && (state == S_READY);
endmodule

// File: tb/tb_udp_snapshot_ctrl.sv
// Self-checking bench for udp_snapshot_ctrl: register reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_udp_snapshot_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  udp_snapshot_ctrl_if bus();

  udp_snapshot_ctrl #(.NUM_WORDS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct { string tg; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] want, input string tag);
    exp_t x;
    sb.push_back('{tg: tag, val: want});
    bus.address = a; bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    x = sb.pop_front();
    chk(x.tg, bus.readdata, x.val);
  endtask

  task automatic idle_stream();
    bus.udp_data_valid = 1'b0; bus.udp_sop = 1'b0; bus.udp_eop = 1'b0; bus.udp_data = '0;
  endtask

  task automatic send(input int n, input logic [31:0] base, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      bus.udp_data_valid = 1'b1;
      bus.udp_data       = base + 32'(i);
      bus.udp_sop        = (i == 0);
      bus.udp_eop        = with_eop && (i == n - 1);
      tick();
    end
    idle_stream();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t x;
    bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;
    idle_stream();
    repeat (3) tick();
    chk("rst_irq", {31'd0, bus.av_irq}, 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    rd(4'd0, 32'h0, "rst_ctrl");
    rd(4'd1, 32'h0, "rst_status");
    rd(4'd2, 32'h0, "rst_drops");

    // Basic 4-word capture
    wr(4'd0, 32'h9);
    rd(4'd1, 32'h001, "armed_status");
    send(4, 32'hA0, 1'b1);
    chk("irq_ready", {31'd0, bus.av_irq}, 32'd1);
    rd(4'd1, 32'h043, "cap4_status");
    for (int i = 0; i < 4; i++) rd(4'(3 + i), 32'hA0 + 32'(i), $sformatf("cap4_word%0d", i));
    tick();
    chk("rdata_hold", bus.readdata, 32'hA3);

    // Frames arriving while READY are dropped, snapshot frozen
    for (int f = 0; f < 3; f++) send(2, 32'hB0 + 32'(f * 16), 1'b1);
    rd(4'd2, 32'd3, "drops3");
    rd(4'd3, 32'hA0, "frozen_w0");
    rd(4'd6, 32'hA3, "frozen_w3");
    wr(4'd0, 32'h11);
    chk("irq_en_off", {31'd0, bus.av_irq}, 32'd0);
    rd(4'd2, 32'd0, "drops_clr");
    wr(4'd0, 32'h13);
    rd(4'd1, 32'h040, "ack_to_idle");

    // Truncated 10-word frame, then ACK with CONT
    wr(4'd0, 32'hD);
    send(10, 32'hC0, 1'b1);
    rd(4'd1, 32'h183, "trunc_status");
    rd(4'd10, 32'hC7, "trunc_w7");
    chk("trunc_irq", {31'd0, bus.av_irq}, 32'd1);
    wr(4'd0, 32'hF);
    chk("ack_irq_low", {31'd0, bus.av_irq}, 32'd0);
    rd(4'd1, 32'h181, "ack_to_armed");

    // Single-word frame, then ACK colliding with sop
    send(1, 32'hD0, 1'b1);
    rd(4'd1, 32'h013, "single_status");
    bus.address = 4'd0; bus.writedata = 32'hF; bus.write = 1'b1;
    bus.udp_data_valid = 1'b1; bus.udp_sop = 1'b1; bus.udp_data = 32'hE0;
    tick();
    bus.write = 1'b0; bus.udp_sop = 1'b0; bus.udp_data = 32'hE1;
    tick();
    bus.udp_eop = 1'b1; bus.udp_data = 32'hE2;
    tick();
    idle_stream();
    rd(4'd1, 32'h011, "acksop_status");
    rd(4'd2, 32'd1, "acksop_drops");
    rd(4'd3, 32'hD0, "acksop_w0");

    // sop inside CAPTURE restarts the frame
    send(3, 32'h10, 1'b0);
    send(2, 32'h20, 1'b1);
    rd(4'd1, 32'h023, "restart_status");
    rd(4'd2, 32'd2, "restart_drops");
    rd(4'd3, 32'h20, "restart_w0");
    rd(4'd4, 32'h21, "restart_w1");
    rd(4'd5, 32'h12, "restart_w2");
    wr(4'd0, 32'hF);

    // ARM cleared mid-capture
    send(2, 32'h30, 1'b0);
    wr(4'd0, 32'h8);
    rd(4'd1, 32'h020, "disarm_status");
    rd(4'd2, 32'd2, "disarm_drops");
    send(2, 32'h40, 1'b1);
    rd(4'd1, 32'h020, "disarm_ignore");

    // Idle gap inside a frame
    wr(4'd0, 32'hD);
    send(2, 32'h70, 1'b0);
    repeat (20) tick();
`ifdef UDP_SNAP_TIMEOUT_EN
    rd(4'd1, 32'h223, "timeout_status");
    chk("timeout_irq", {31'd0, bus.av_irq}, 32'd1);
`else
    rd(4'd1, 32'h022, "no_timeout_status");
`endif

    // Asynchronous reset during CAPTURE
    wr(4'd0, 32'hA);
    wr(4'd0, 32'hD);
    send(3, 32'h50, 1'b0);
    rd(4'd1, 32'h022, "precap_status");
    rd(4'd5, 32'h52, "precap_w2");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rdata", bus.readdata, 32'd0);
    chk("async_irq", {31'd0, bus.av_irq}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd(4'd0, 32'h0, "postrst_ctrl");
    rd(4'd1, 32'h0, "postrst_status");
    rd(4'd2, 32'h0, "postrst_drops");
    rd(4'd3, 32'h0, "postrst_w0");
    rd(4'd5, 32'h0, "postrst_w2");
    send(3, 32'h60, 1'b1);
    rd(4'd1, 32'h0, "noarm_status");
    rd(4'd3, 32'h0, "noarm_w0");

    // Read and write to the same address in one cycle returns the old value
    sb.push_back('{tg: "rw_same", val: 32'h0});
    bus.address = 4'd0; bus.writedata = 32'h9; bus.write = 1'b1; bus.read = 1'b1;
    tick();
    bus.write = 1'b0; bus.read = 1'b0;
    x = sb.pop_front();
    chk(x.tg, bus.readdata, x.val);
    rd(4'd0, 32'h9, "rw_after");
    wr(4'd1, 32'hFFFF);
    rd(4'd1, 32'h001, "ro_status");
    rd(4'd11, 32'h0, "unmapped_11");
    rd(4'd15, 32'h0, "unmapped_15");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
